// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit between the execute stage and the mem stage. It takes one
// load or store from EX, runs the req/gnt/rvalid handshake on the data bus,
// lines up byte enables and store data with the addressed lanes, extends
// load data, and holds the pipeline while an access is in flight.
//
// Ports
//   clk, arst_n           clock; synchronous active-low reset
//   ex_valid_i            EX presents a memory op this cycle
//   ex_load_i/ex_store_i  op type (both high is treated as a fault)
//   ex_funct3_i           RV32I funct3 of the load/store
//   ex_addr_i             effective byte address
//   ex_wdata_i            store source (rs2)
//   lsu_stall_o           hold IF/ID/EX while an access is accepted/in flight
//   dbus_req_o/we/addr/be/wdata   data bus request side
//   dbus_gnt_i/rvalid_i/rdata_i   data bus response side
//   lsu_done_o            one-cycle completion pulse
//   lsu_rdata_o           extended load result (held until the next load)
//   lsu_fault_o           with done: misaligned or illegal funct3, no bus access
//   lsu_err_o             with done: bus timeout
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        ex_valid_i,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        lsu_stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_gnt_i,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_fault_o,
    output logic        lsu_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q;
    logic [TO_W-1:0] toCnt_q;
    logic            isLoad_q;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;
    logic            req_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            done_q;
    logic            fault_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic            accept;
    logic            illegal_d;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [31:0]     loadResult_d;

    // An op with both type bits set is still accepted so that it can be
    // reported as a fault instead of silently vanishing.
    assign accept = (state_q == IDLE) && ex_valid_i && (ex_load_i || ex_store_i);

    // Stall covers the accept cycle combinationally so EX holds the op while
    // the request is being latched; DONE lets the pipeline move again.
    assign lsu_stall_o = accept || (state_q == REQ) || (state_q == WAIT);

    // Legality: funct3 must be a real load/store encoding and the address
    // must be naturally aligned for the access size.
    always_comb begin
        illegal_d = 1'b0;
        if (ex_load_i && ex_store_i) begin
            illegal_d = 1'b1;
        end else if (ex_load_i) begin
            case (ex_funct3_i)
                3'b000, 3'b100: illegal_d = 1'b0;
                3'b001, 3'b101: illegal_d = ex_addr_i[0];
                3'b010:         illegal_d = |ex_addr_i[1:0];
                default:        illegal_d = 1'b1;
            endcase
        end else begin
            case (ex_funct3_i)
                3'b000:  illegal_d = 1'b0;
                3'b001:  illegal_d = ex_addr_i[0];
                3'b010:  illegal_d = |ex_addr_i[1:0];
                default: illegal_d = 1'b1;
            endcase
        end
    end

    // Store data is replicated across the word so whichever lanes are enabled
    // carry the right bytes; loads always fetch the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_wdata_i;
        case (ex_funct3_i[1:0])
            2'b00: begin
                wdata_d = {4{ex_wdata_i[7:0]}};
                if (!ex_load_i) be_d = 4'b0001 << ex_addr_i[1:0];
            end
            2'b01: begin
                wdata_d = {2{ex_wdata_i[15:0]}};
                if (!ex_load_i) be_d = 4'b0011 << ex_addr_i[1:0];
            end
            default: begin
                wdata_d = ex_wdata_i;
                be_d    = 4'b1111;
            end
        endcase
    end

    // Lane selection and extension of the returned word, using the byte
    // offset and funct3 captured when the op was accepted.
    always_comb begin
        case (offset_q)
            2'd0:    loadByte = dbus_rdata_i[7:0];
            2'd1:    loadByte = dbus_rdata_i[15:8];
            2'd2:    loadByte = dbus_rdata_i[23:16];
            default: loadByte = dbus_rdata_i[31:24];
        endcase
        loadHalf = offset_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (funct3_q)
            3'b000:  loadResult_d = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadResult_d = {24'b0, loadByte};
            3'b001:  loadResult_d = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadResult_d = {16'b0, loadHalf};
            default: loadResult_d = dbus_rdata_i;
        endcase
    end

    // Main controller. Done/fault/err default low each cycle so they only
    // ever form a single-cycle pulse on entry to DONE. The timeout counter
    // restarts on every entry to REQ or WAIT.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            toCnt_q  <= '0;
            isLoad_q <= 1'b0;
            funct3_q <= 3'b0;
            offset_q <= 2'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'b0;
            be_q     <= 4'b0;
            wdata_q  <= 32'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        isLoad_q <= ex_load_i;
                        funct3_q <= ex_funct3_i;
                        offset_q <= ex_addr_i[1:0];
                        toCnt_q  <= '0;
                        if (illegal_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= ex_store_i;
                            addr_q  <= {ex_addr_i[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (dbus_gnt_i) begin
                        req_q   <= 1'b0;
                        toCnt_q <= '0;
                        if (isLoad_q) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (toCnt_q == TO_LAST) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        if (isLoad_q) rdata_q <= 32'b0;
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (dbus_rvalid_i) begin
                        rdata_q <= loadResult_d;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (toCnt_q == TO_LAST) begin
                        rdata_q <= 32'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        toCnt_q <= toCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dbus_req_o   = req_q;
    assign dbus_we_o    = we_q;
    assign dbus_addr_o  = addr_q;
    assign dbus_be_o    = be_q;
    assign dbus_wdata_o = wdata_q;
    assign lsu_done_o   = done_q;
    assign lsu_fault_o  = fault_q;
    assign lsu_err_o    = err_q;
    assign lsu_rdata_o  = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Self-checking bench for lsu_ctrl. Each op pushes its expected outcome onto
// a scoreboard queue; a small bus responder grants/returns data after the
// requested delays, and the outcome is popped and compared at the done pulse.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    typedef struct {
        logic        fault;
        logic        err;
        logic        chkRd;
        logic [31:0] rdata;
        int          latency;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chkWd;
        logic [31:0] wdata;
    } exp_t;

    logic        clk;
    logic        arst_n;
    logic        ex_valid_i;
    logic        ex_load_i;
    logic        ex_store_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_stall_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_fault_o;
    logic        lsu_err_o;

    int   vectorCount;
    int   miscompareCount;
    exp_t scoreboard[$];

    lsu_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .ex_valid_i    (ex_valid_i),
        .ex_load_i     (ex_load_i),
        .ex_store_i    (ex_store_i),
        .ex_funct3_i   (ex_funct3_i),
        .ex_addr_i     (ex_addr_i),
        .ex_wdata_i    (ex_wdata_i),
        .lsu_stall_o   (lsu_stall_o),
        .dbus_req_o    (dbus_req_o),
        .dbus_we_o     (dbus_we_o),
        .dbus_addr_o   (dbus_addr_o),
        .dbus_be_o     (dbus_be_o),
        .dbus_wdata_o  (dbus_wdata_o),
        .dbus_gnt_i    (dbus_gnt_i),
        .dbus_rvalid_i (dbus_rvalid_i),
        .dbus_rdata_i  (dbus_rdata_i),
        .lsu_done_o    (lsu_done_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_fault_o   (lsu_fault_o),
        .lsu_err_o     (lsu_err_o)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic fault, input logic err,
                                   input logic chkRd, input logic [31:0] rdata,
                                   input int latency, input logic we,
                                   input logic [31:0] addr, input logic [3:0] be,
                                   input logic chkWd, input logic [31:0] wdata);
        exp_t e;
        e.fault   = fault;
        e.err     = err;
        e.chkRd   = chkRd;
        e.rdata   = rdata;
        e.latency = latency;
        e.we      = we;
        e.addr    = addr;
        e.be      = be;
        e.chkWd   = chkWd;
        e.wdata   = wdata;
        return e;
    endfunction

    // Drive one op, respond on the bus after gntDelay REQ cycles and rvDelay
    // cycles past the grant (negative = never), then score the completion.
    task automatic applyStimulus(input string tag, input logic ld, input logic st,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int gntDelay, input int rvDelay, input exp_t e);
        int   cyc;
        int   stallCnt;
        int   reqCnt;
        int   rvCnt;
        logic reqSeen;
        logic gotGnt;
        logic finished;
        exp_t front;
        exp_t got;
        scoreboard.push_back(e);
        cyc      = 1;
        reqCnt   = 0;
        rvCnt    = 0;
        reqSeen  = 1'b0;
        gotGnt   = 1'b0;
        finished = 1'b0;
        @(posedge clk); #1;
        ex_valid_i    = 1'b1;
        ex_load_i     = ld;
        ex_store_i    = st;
        ex_funct3_i   = f3;
        ex_addr_i     = addr;
        ex_wdata_i    = wdata;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, " stall_accept"}, 32'(lsu_stall_o), 32'd1);
        checkOutput({tag, " done_low_accept"}, 32'(lsu_done_o), 32'd0);
        stallCnt = lsu_stall_o ? 1 : 0;
        while (!finished && cyc < 60) begin
            @(posedge clk); #1;
            ex_valid_i    = 1'b0;
            ex_load_i     = 1'b0;
            ex_store_i    = 1'b0;
            dbus_gnt_i    = 1'b0;
            dbus_rvalid_i = 1'b0;
            if (gotGnt && ld) begin
                rvCnt++;
                if (rvCnt == rvDelay) dbus_rvalid_i = 1'b1;
            end
            if (dbus_req_o) begin
                if (reqCnt == gntDelay) begin
                    dbus_gnt_i = 1'b1;
                    gotGnt     = 1'b1;
                end
                reqCnt++;
            end
            dbus_rdata_i = dbus_rvalid_i ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            cyc++;
            if (dbus_req_o && (reqCnt == 1 || dbus_gnt_i) && scoreboard.size() > 0) begin
                front = scoreboard[0];
                checkOutput({tag, " bus_we"},   32'(dbus_we_o), 32'(front.we));
                checkOutput({tag, " bus_addr"}, dbus_addr_o,    front.addr);
                checkOutput({tag, " bus_be"},   32'(dbus_be_o), 32'(front.be));
                if (front.chkWd) checkOutput({tag, " bus_wdata"}, dbus_wdata_o, front.wdata);
            end
            if (dbus_req_o) reqSeen = 1'b1;
            if (lsu_done_o) finished = 1'b1;
            else if (lsu_stall_o) stallCnt++;
        end
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        checkOutput({tag, " done_seen"}, 32'(finished), 32'd1);
        if (finished) begin
            got = scoreboard.pop_front();
            checkOutput({tag, " fault"},      32'(lsu_fault_o), 32'(got.fault));
            checkOutput({tag, " err"},        32'(lsu_err_o),   32'(got.err));
            checkOutput({tag, " latency"},    32'(cyc),         32'(got.latency));
            checkOutput({tag, " stall_done"}, 32'(lsu_stall_o), 32'd0);
            checkOutput({tag, " stall_cnt"},  32'(stallCnt),    32'(got.latency - 1));
            checkOutput({tag, " req_seen"},   32'(reqSeen),     32'(!got.fault));
            checkOutput({tag, " req_low"},    32'(dbus_req_o),  32'd0);
            if (got.chkRd) checkOutput({tag, " rdata"}, lsu_rdata_o, got.rdata);
        end else begin
            void'(scoreboard.pop_front());
        end
    endtask

    initial begin
        int   activity;
        vectorCount     = 0;
        miscompareCount = 0;
        arst_n        = 1'b0;
        ex_valid_i    = 1'b0;
        ex_load_i     = 1'b0;
        ex_store_i    = 1'b0;
        ex_funct3_i   = 3'b0;
        ex_addr_i     = 32'b0;
        ex_wdata_i    = 32'b0;
        dbus_gnt_i    = 1'b0;
        dbus_rvalid_i = 1'b0;
        dbus_rdata_i  = 32'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset req",   32'(dbus_req_o),  32'd0);
        checkOutput("reset done",  32'(lsu_done_o),  32'd0);
        checkOutput("reset stall", 32'(lsu_stall_o), 32'd0);
        checkOutput("reset rdata", lsu_rdata_o,      32'd0);
        checkOutput("reset bus",   32'({dbus_we_o, dbus_be_o, lsu_fault_o, lsu_err_o}), 32'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;

        applyStimulus("LB", 1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_5512, 0, 1,
                      mkExp(0, 0, 1, 32'hFFFF_FF80, 4, 0, 32'h0000_1000, 4'b1111, 0, 32'h0));
        applyStimulus("SH", 0, 1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 3, -1,
                      mkExp(0, 0, 1, 32'hFFFF_FF80, 6, 1, 32'h0000_2000, 4'b1100, 1, 32'hBEEF_BEEF));
        applyStimulus("LW_mis", 1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1,
                      mkExp(1, 0, 0, 32'h0, 2, 0, 32'h0, 4'b0, 0, 32'h0));
        applyStimulus("LHU_to", 1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h0, 0, -1,
                      mkExp(0, 1, 1, 32'h0, 19, 0, 32'h0000_4000, 4'b1111, 0, 32'h0));
        applyStimulus("SW", 0, 1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 0, -1,
                      mkExp(0, 0, 1, 32'h0, 3, 1, 32'h0000_5000, 4'b1111, 1, 32'hCAFE_F00D));
        applyStimulus("LBU_b2b", 1, 0, 3'b100, 32'h0000_5000, 32'h0, 32'h0000_00F0, 0, 1,
                      mkExp(0, 0, 1, 32'h0000_00F0, 4, 0, 32'h0000_5000, 4'b1111, 0, 32'h0));
        applyStimulus("LH", 1, 0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_1234, 1, 2,
                      mkExp(0, 0, 1, 32'hFFFF_8001, 6, 0, 32'h0000_6000, 4'b1111, 0, 32'h0));
        applyStimulus("SB", 0, 1, 3'b000, 32'h0000_8001, 32'hAABB_CCDD, 32'h0, 0, -1,
                      mkExp(0, 0, 1, 32'hFFFF_8001, 3, 1, 32'h0000_8000, 4'b0010, 1, 32'hDDDD_DDDD));
        applyStimulus("L_f3bad", 1, 0, 3'b011, 32'h0000_9000, 32'h0, 32'h0, 0, 1,
                      mkExp(1, 0, 0, 32'h0, 2, 0, 32'h0, 4'b0, 0, 32'h0));
        applyStimulus("LDST_both", 1, 1, 3'b010, 32'h0000_9004, 32'h0, 32'h0, 0, 1,
                      mkExp(1, 0, 0, 32'h0, 2, 0, 32'h0, 4'b0, 0, 32'h0));
        applyStimulus("SH_mis", 0, 1, 3'b001, 32'h0000_9003, 32'h1111_2222, 32'h0, 0, -1,
                      mkExp(1, 0, 0, 32'h0, 2, 0, 32'h0, 4'b0, 0, 32'h0));
        applyStimulus("S_f3bad", 0, 1, 3'b100, 32'h0000_9008, 32'h1111_2222, 32'h0, 0, -1,
                      mkExp(1, 0, 0, 32'h0, 2, 0, 32'h0, 4'b0, 0, 32'h0));

        // Valid with neither type bit must be ignored entirely.
        @(posedge clk); #1;
        ex_valid_i = 1'b1;
        ex_load_i  = 1'b0;
        ex_store_i = 1'b0;
        @(negedge clk);
        checkOutput("ignored stall", 32'(lsu_stall_o), 32'd0);
        activity = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ex_valid_i = 1'b0;
            @(negedge clk);
            if (dbus_req_o || lsu_done_o || lsu_stall_o) activity++;
        end
        checkOutput("ignored activity", 32'(activity), 32'd0);

        // Reset while a load sits in WAIT.
        @(posedge clk); #1;
        ex_valid_i  = 1'b1;
        ex_load_i   = 1'b1;
        ex_store_i  = 1'b0;
        ex_funct3_i = 3'b010;
        ex_addr_i   = 32'h0000_9100;
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        ex_load_i  = 1'b0;
        dbus_gnt_i = dbus_req_o;
        @(posedge clk); #1;
        dbus_gnt_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_wait inflight", 32'(lsu_stall_o), 32'd1);
        @(posedge clk); #1;
        arst_n = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_wait req",   32'(dbus_req_o),  32'd0);
        checkOutput("rst_wait stall", 32'(lsu_stall_o), 32'd0);
        checkOutput("rst_wait done",  32'(lsu_done_o),  32'd0);
        checkOutput("rst_wait addr",  dbus_addr_o,      32'd0);
        checkOutput("rst_wait flags", 32'({dbus_we_o, dbus_be_o, lsu_fault_o, lsu_err_o}), 32'd0);
        checkOutput("rst_wait rdata", lsu_rdata_o,      32'd0);
        activity = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            dbus_rvalid_i = 1'b1;
            dbus_rdata_i  = 32'h5555_5555;
            @(negedge clk);
            if (lsu_done_o) activity++;
        end
        dbus_rvalid_i = 1'b0;
        checkOutput("rst_wait no_done", 32'(activity), 32'd0);

        applyStimulus("LW_after_rst", 1, 0, 3'b010, 32'h0000_A000, 32'h0, 32'h1234_5678, 0, 1,
                      mkExp(0, 0, 1, 32'h1234_5678, 4, 0, 32'h0000_A000, 4'b1111, 0, 32'h0));

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("final done_pulse", 32'(lsu_done_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
